// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall controller for the 5-stage ARM pipeline.
// Define FWD_HAZARD_FORWARDING_EN for operand forwarding; otherwise every RAW dependency stalls.
module fwd_hazard_unit #(
   parameter int REG_AW      = 4,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_AW-1:0]      id_src1,
   input  logic [REG_AW-1:0]      id_src2,
   input  logic                   id_src1_used,
   input  logic                   id_src2_used,
   input  logic                   id_valid,
   input  logic                   id_wb_en,
   input  logic                   id_mem_r_en,
   input  logic [REG_AW-1:0]      id_dest,
   input  logic                   flush,
   output logic                   hazard,
   output logic [1:0]             sel_src1,
   output logic [1:0]             sel_src2,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;
   localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

   logic              exe_valid, exe_wb_en, exe_mem_r_en;
   logic [REG_AW-1:0] exe_dest;
   // A load already in MEM has its data by the time the consumer is in EXE,
   // so the MEM slot does not need the load flag.
   logic              mem_valid, mem_wb_en;
   logic [REG_AW-1:0] mem_dest;

   logic       exe_m1, exe_m2, mem_m1, mem_m2;
   logic       advance;
   logic [1:0] sel1_d, sel2_d;

   always_comb begin
      exe_m1 = exe_valid & exe_wb_en & id_src1_used & (exe_dest == id_src1);
      exe_m2 = exe_valid & exe_wb_en & id_src2_used & (exe_dest == id_src2);
      mem_m1 = mem_valid & mem_wb_en & id_src1_used & (mem_dest == id_src1);
      mem_m2 = mem_valid & mem_wb_en & id_src2_used & (mem_dest == id_src2);
`ifdef FWD_HAZARD_FORWARDING_EN
      hazard = ~rst & id_valid & ~flush & exe_mem_r_en & (exe_m1 | exe_m2);
      // The EXE slot holds the youngest producer, so it takes priority.
      sel1_d = exe_m1 ? 2'd1 : (mem_m1 ? 2'd2 : 2'd0);
      sel2_d = exe_m2 ? 2'd1 : (mem_m2 ? 2'd2 : 2'd0);
`else
      hazard = ~rst & id_valid & ~flush & (exe_m1 | exe_m2 | mem_m1 | mem_m2);
      sel1_d = 2'd0;
      sel2_d = 2'd0;
`endif
      advance = ~hazard & ~flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         exe_valid    <= 1'b0;
         exe_wb_en    <= 1'b0;
         exe_mem_r_en <= 1'b0;
         exe_dest     <= '0;
         mem_valid    <= 1'b0;
         mem_wb_en    <= 1'b0;
         mem_dest     <= '0;
         sel_src1     <= 2'd0;
         sel_src2     <= 2'd0;
         stall_count  <= '0;
      end else begin
         mem_valid    <= exe_valid;
         mem_wb_en    <= exe_wb_en;
         mem_dest     <= exe_dest;
         exe_valid    <= advance & id_valid;
         exe_wb_en    <= id_wb_en;
         exe_mem_r_en <= id_mem_r_en;
         exe_dest     <= id_dest;
         sel_src1     <= advance ? sel1_d : 2'd0;
         sel_src2     <= advance ? sel2_d : 2'd0;
         if (hazard && (stall_count != CNT_MAX))
            stall_count <= stall_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit; expectations follow FWD_HAZARD_FORWARDING_EN.
module tb_fwd_hazard_unit;

   typedef struct {
      logic       v, wb, mr;
      logic [3:0] dest;
      logic [3:0] s1;
      logic       u1;
      logic [3:0] s2;
      logic       u2;
      logic       fl;
      logic       eh;
      logic [1:0] es1, es2;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  id_src1 = '0, id_src2 = '0, id_dest = '0;
   logic        id_src1_used = 1'b0, id_src2_used = 1'b0;
   logic        id_valid = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0, flush = 1'b0;
   logic        hazard, hazard_s;
   logic [1:0]  sel_src1, sel_src2, sel_s1, sel_s2;
   logic [15:0] stall_count;
   logic [2:0]  cnt_s;

   int total = 0;
   int bad   = 0;
   int exp_cnt = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   fwd_hazard_unit dut (
      .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
      .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
      .id_dest(id_dest), .flush(flush), .hazard(hazard),
      .sel_src1(sel_src1), .sel_src2(sel_src2), .stall_count(stall_count)
   );

   // Narrow counter instance to reach saturation quickly.
   fwd_hazard_unit #(.REG_AW(4), .STALL_CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
      .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
      .id_dest(id_dest), .flush(flush), .hazard(hazard_s),
      .sel_src1(sel_s1), .sel_src2(sel_s2), .stall_count(cnt_s)
   );

   function automatic vec_t mk(logic v, logic wb, logic mr, int dest,
                               int s1, logic u1, int s2, logic u2, logic fl,
                               logic eh, int es1, int es2);
      vec_t t;
      t.v = v; t.wb = wb; t.mr = mr; t.dest = 4'(dest);
      t.s1 = 4'(s1); t.u1 = u1; t.s2 = 4'(s2); t.u2 = u2; t.fl = fl;
      t.eh = eh; t.es1 = 2'(es1); t.es2 = 2'(es2);
      return t;
   endfunction

   function automatic vec_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic check(string name, int got, int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic drive(vec_t t);
      id_valid = t.v; id_wb_en = t.wb; id_mem_r_en = t.mr; id_dest = t.dest;
      id_src1 = t.s1; id_src1_used = t.u1; id_src2 = t.s2; id_src2_used = t.u2;
      flush = t.fl;
   endtask

   // Drive just after an edge, check hazard mid-cycle, registered outputs after the edge.
   task automatic apply(vec_t t, string tag);
      drive(t);
      #3;
      check({tag, " hazard"}, int'(hazard), int'(t.eh));
      @(posedge clk);
      #1;
      if (t.eh) exp_cnt++;
      check({tag, " sel_src1"}, int'(sel_src1), int'(t.es1));
      check({tag, " sel_src2"}, int'(sel_src2), int'(t.es2));
      check({tag, " stall_count"}, int'(stall_count), exp_cnt);
      check({tag, " stall_count_sat"}, int'(cnt_s), (exp_cnt > 7) ? 7 : exp_cnt);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(nop());
      @(posedge clk);
      @(posedge clk);
      #1;
      exp_cnt = 0;
      check("reset hazard", int'(hazard), 0);
      check("reset sel_src1", int'(sel_src1), 0);
      check("reset sel_src2", int'(sel_src2), 0);
      check("reset stall_count", int'(stall_count), 0);
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

`ifdef FWD_HAZARD_FORWARDING_EN
      // ADD R1 ; SUB R2,R1,R3
      tbl.push_back(mk(1,1,0, 1,  2,1, 3,1, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 2,  1,1, 3,1, 0, 0, 1,0));
      tbl.push_back(nop()); tbl.push_back(nop());
      // ADD R1 ; NOP ; ORR R4,R5,R1
      tbl.push_back(mk(1,1,0, 1,  8,1, 9,1, 0, 0, 0,0));
      tbl.push_back(nop());
      tbl.push_back(mk(1,1,0, 4,  5,1, 1,1, 0, 0, 0,2));
      tbl.push_back(nop()); tbl.push_back(nop());
      // LDR R6 ; ADD R7,R6,R6 (one stall, then forward from MEM)
      tbl.push_back(mk(1,1,1, 6,  0,1, 0,0, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 7,  6,1, 6,1, 0, 1, 0,0));
      tbl.push_back(mk(1,1,0, 7,  6,1, 6,1, 0, 0, 2,2));
      tbl.push_back(nop()); tbl.push_back(nop());
      // ADD R1 ; ADD R1 ; reader of R1 (youngest wins)
      tbl.push_back(mk(1,1,0, 1,  2,1, 3,1, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 1,  4,1, 5,1, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 8,  1,1, 1,1, 0, 0, 1,1));
      tbl.push_back(nop()); tbl.push_back(nop());
      // LDR R6 ; dependent with flush ; reader after the bubble
      tbl.push_back(mk(1,1,1, 6,  0,1, 0,0, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 7,  6,1, 6,1, 1, 0, 0,0));
      tbl.push_back(mk(1,1,0, 9,  6,1, 6,1, 0, 0, 2,2));
      tbl.push_back(nop()); tbl.push_back(nop());
      // unused sources are ignored
      tbl.push_back(mk(1,1,0, 3, 10,1,11,1, 0, 0, 0,0));
      tbl.push_back(mk(1,0,0, 0,  3,0, 3,0, 0, 0, 0,0));
      tbl.push_back(mk(1,1,1, 5,  0,1, 0,0, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 8,  5,0, 5,0, 0, 0, 0,0));
      tbl.push_back(nop()); tbl.push_back(nop());
      // R15 is an ordinary register
      tbl.push_back(mk(1,1,0,15,  0,1, 0,1, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 8, 15,1, 7,1, 0, 0, 1,0));
      tbl.push_back(nop()); tbl.push_back(nop());
      // load-use on src2 only
      tbl.push_back(mk(1,1,1, 2,  0,1, 0,0, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 8,  9,1, 2,1, 0, 1, 0,0));
      tbl.push_back(mk(1,1,0, 8,  9,1, 2,1, 0, 0, 0,2));
      tbl.push_back(nop()); tbl.push_back(nop());
`else
      // ADD R1 ; SUB R2,R1,R3 stalls two cycles
      tbl.push_back(mk(1,1,0, 1,  2,1, 3,1, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 2,  1,1, 3,1, 0, 1, 0,0));
      tbl.push_back(mk(1,1,0, 2,  1,1, 3,1, 0, 1, 0,0));
      tbl.push_back(mk(1,1,0, 2,  1,1, 3,1, 0, 0, 0,0));
      tbl.push_back(nop()); tbl.push_back(nop());
      // LDR R6 ; ADD R7,R6,R6
      tbl.push_back(mk(1,1,1, 6,  0,1, 0,0, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 7,  6,1, 6,1, 0, 1, 0,0));
      tbl.push_back(mk(1,1,0, 7,  6,1, 6,1, 0, 1, 0,0));
      tbl.push_back(mk(1,1,0, 7,  6,1, 6,1, 0, 0, 0,0));
      tbl.push_back(nop()); tbl.push_back(nop());
      // LDR R6 ; dependent with flush ; reader sees the load in MEM
      tbl.push_back(mk(1,1,1, 6,  0,1, 0,0, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 7,  6,1, 6,1, 1, 0, 0,0));
      tbl.push_back(mk(1,1,0, 9,  6,1, 6,1, 0, 1, 0,0));
      tbl.push_back(mk(1,1,0, 9,  6,1, 6,1, 0, 0, 0,0));
      tbl.push_back(nop()); tbl.push_back(nop());
      // unused sources are ignored
      tbl.push_back(mk(1,1,0, 3, 10,1,11,1, 0, 0, 0,0));
      tbl.push_back(mk(1,0,0, 0,  3,0, 3,0, 0, 0, 0,0));
      tbl.push_back(nop()); tbl.push_back(nop());
      // R15 is an ordinary register
      tbl.push_back(mk(1,1,0,15,  0,1, 0,1, 0, 0, 0,0));
      tbl.push_back(mk(1,1,0, 8, 14,1,15,1, 0, 1, 0,0));
      tbl.push_back(mk(1,1,0, 8, 14,1,15,1, 0, 1, 0,0));
      tbl.push_back(mk(1,1,0, 8, 14,1,15,1, 0, 0, 0,0));
      tbl.push_back(nop()); tbl.push_back(nop());
`endif

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("vec%0d", i));

      // Reset asserted while a load-use stall is pending.
      apply(mk(1,1,1, 6, 0,1, 0,0, 0, 0, 0,0), "midrst ldr");
      drive(mk(1,1,0, 7, 6,1, 6,1, 0, 0, 0,0));
      #1;
      check("midrst hazard before rst", int'(hazard), 1);
      rst = 1'b1;
      #1;
      check("midrst hazard in rst", int'(hazard), 0);
      @(posedge clk);
      #1;
      exp_cnt = 0;
      check("midrst sel_src1", int'(sel_src1), 0);
      check("midrst sel_src2", int'(sel_src2), 0);
      check("midrst stall_count", int'(stall_count), 0);
      rst = 1'b0;
      apply(mk(1,1,0, 7, 6,1, 6,1, 0, 0, 0,0), "midrst after");

      // Repeated load-use pairs drive the narrow counter into saturation.
      for (int k = 0; k < 10; k++) begin
         apply(mk(1,1,1, 6, 0,1, 0,0, 0, 0, 0,0), $sformatf("sat%0d ldr", k));
         apply(mk(1,1,0, 7, 6,1, 6,1, 0, 1, 0,0), $sformatf("sat%0d stall", k));
`ifdef FWD_HAZARD_FORWARDING_EN
         apply(mk(1,1,0, 7, 6,1, 6,1, 0, 0, 2,2), $sformatf("sat%0d go", k));
`else
         apply(mk(1,1,0, 7, 6,1, 6,1, 0, 1, 0,0), $sformatf("sat%0d stall2", k));
         apply(mk(1,1,0, 7, 6,1, 6,1, 0, 0, 0,0), $sformatf("sat%0d go", k));
`endif
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
